tpu: RTL and testbench



---
 rtl/tpu_pkg.sv | 54 +++++
 rtl/tpu_mac_row.sv | 57 +++++
 rtl/tpu.sv | 204 ++++++++++++++++++++
 tb/tb_tpu.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared constants, FSM state type and lane helper for the 4x4 int16
// matrix-multiply accelerator.
package tpu_pkg;

    // Bus window: 0x4000_0000 - 0x4001_FFFF, 8-byte words
    localparam logic [63:0] TPU_BASE = 64'h0000_0000_4000_0000;
    localparam logic [46:0] WIN_TAG  = TPU_BASE[63:17];

    // Word indices inside the window
    localparam logic [13:0] ENABLE_W = 14'h2E00;
    localparam logic [13:0] FINISH_W = 14'h2E01;

    // Unified buffer row addresses of the operands and the result
    localparam logic [7:0] A_BASE = 8'h10;
    localparam logic [7:0] B_BASE = 8'h20;
    localparam logic [7:0] C_BASE = 8'h00;

    // Geometry
    localparam int LANE_W    = 16;
    localparam int DIM       = 4;
    localparam int ROW_W     = LANE_W * DIM;
    localparam int PROD_W    = 32;
    localparam int ACC_W     = 34;
    localparam int BUF_DEPTH = 256;
    localparam int BUF_AW    = 8;

    // Saturation bounds for the optional clamped writeback
    localparam logic signed [ACC_W-1:0] SAT_MAX = 34'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -34'sd32768;

    // Engine sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_MAC,
        ST_WR,
        ST_DONE
    } state_t;

    // Source of the data returned for a bus read
    typedef enum logic [1:0] {
        RSEL_ZERO,
        RSEL_BUF,
        RSEL_ENABLE,
        RSEL_FINISH
    } rsel_t;

    // Extract signed lane idx from a packed buffer row
    function automatic logic signed [LANE_W-1:0] lane_of(input logic [ROW_W-1:0] row,
                                                         input int idx);
        return row[idx*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/tpu_mac_row.sv
// tpu_mac_row: four parallel signed 16x16 multiply-accumulate lanes sharing one
// A element. Each lane keeps a 34-bit accumulator; the result is either the low
// 16 bits (wrap) or, with TPU_SATURATE_EN defined, clamped to int16 range.
module tpu_mac_row
    import tpu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     acc_en,
    input  logic signed [LANE_W-1:0] a,
    input  logic [ROW_W-1:0]         b_row,
    output logic [ROW_W-1:0]         result
);

    genvar gi;
    generate
        for (gi = 0; gi < DIM; gi++) begin : g_lane
            logic signed [LANE_W-1:0] b;
            logic signed [PROD_W-1:0] prod;
            logic signed [ACC_W-1:0]  acc_reg;
            logic [LANE_W-1:0]        lane_res;

            assign b    = b_row[gi*LANE_W +: LANE_W];
            assign prod = a * b;

            // Accumulator: cleared after each writeback, adds one product per MAC step
            always_ff @(posedge clk) begin
                if (!rst) begin
                    acc_reg <= '0;
                end else if (clear) begin
                    acc_reg <= '0;
                end else if (acc_en) begin
                    acc_reg <= acc_reg + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                end
            end

`ifdef TPU_SATURATE_EN
            // Clamp the full-width sum into int16 range
            always_comb begin
                lane_res = acc_reg[LANE_W-1:0];
                if (acc_reg > SAT_MAX) begin
                    lane_res = 16'h7FFF;
                end else if (acc_reg < SAT_MIN) begin
                    lane_res = 16'h8000;
                end
            end
`else
            // Wrap-around: keep the low 16 bits of the sum
            assign lane_res = acc_reg[LANE_W-1:0];
`endif

            assign result[gi*LANE_W +: LANE_W] = lane_res;
        end
    endgenerate

endmodule

// File: rtl/tpu.sv
// tpu: memory-mapped 4x4 int16 matrix-multiply accelerator (C = A x B).
// Host loads A (rows 0x10-0x13) and B (rows 0x20-0x23) into the unified
// buffer, writes ENABLE, polls FINISH and reads C from rows 0x00-0x03.
// The buffer has a dedicated bus read port, so bus reads are never stalled by
// the engine; bus writes to the buffer are dropped while the engine is busy.
// Optional macro TPU_SATURATE_EN: clamp results to int16 instead of wrapping.
module tpu
    import tpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        axi_req,
    input  logic        axi_we,
    input  logic [63:0] axi_addr,
    input  logic [63:0] axi_wdata,
    output logic [63:0] axi_rdata
);

    // ---------------- bus decode ----------------
    logic        hit;
    logic [13:0] word;
    logic        buf_hit;
    logic        en_hit;
    logic        fin_hit;
    logic        bus_wr;
    logic        bus_rd;
    logic        unused_addr;

    assign hit         = (axi_addr[63:17] == WIN_TAG);
    assign word        = axi_addr[16:3];
    assign buf_hit     = hit && (word[13:8] == 6'd0);
    assign en_hit      = hit && (word == ENABLE_W);
    assign fin_hit     = hit && (word == FINISH_W);
    assign bus_wr      = axi_req && axi_we;
    assign bus_rd      = axi_req && !axi_we;
    assign unused_addr = ^axi_addr[2:0];

    // ---------------- engine state ----------------
    state_t         state_reg;
    logic [1:0]     row_reg;
    logic [1:0]     k_reg;
    logic           busy_reg;
    logic           done_reg;
    logic [ROW_W-1:0] a_row_reg;
    logic           start;

    assign start = bus_wr && en_hit && axi_wdata[0] && (state_reg == ST_IDLE) && !busy_reg;

    // ---------------- unified buffer ----------------
    logic [ROW_W-1:0]  mem [BUF_DEPTH];
    logic [ROW_W-1:0]  eng_rd_reg;
    logic [ROW_W-1:0]  bus_rd_reg;
    logic [BUF_AW-1:0] eng_addr;
    logic              mem_we;
    logic [BUF_AW-1:0] mem_waddr;
    logic [ROW_W-1:0]  mem_wdata;
    logic [ROW_W-1:0]  mac_result;

    // Engine read address is the row needed in the following cycle, so the
    // registered read lines up with the state that consumes it.
    always_comb begin
        eng_addr = A_BASE;
        case (state_reg)
            ST_RD_A: eng_addr = B_BASE;
            ST_MAC:  eng_addr = B_BASE + 8'(k_reg) + 8'd1;
            ST_WR:   eng_addr = A_BASE + 8'(row_reg) + 8'd1;
            default: eng_addr = A_BASE;
        endcase
    end

    // Single write port: engine writeback has priority; bus writes only when idle
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = word[BUF_AW-1:0];
        mem_wdata = axi_wdata;
        if (rst && (state_reg == ST_WR)) begin
            mem_we    = 1'b1;
            mem_waddr = C_BASE + 8'(row_reg);
            mem_wdata = mac_result;
        end else if (rst && bus_wr && buf_hit && !busy_reg) begin
            mem_we    = 1'b1;
        end
    end

    // Buffer array: one write port, registered engine and bus read ports
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        eng_rd_reg <= mem[eng_addr];
        bus_rd_reg <= mem[word[BUF_AW-1:0]];
    end

    // ---------------- MAC datapath ----------------
    logic signed [LANE_W-1:0] a_lane;
    logic                     mac_clear;
    logic                     mac_acc;

    assign a_lane    = lane_of(a_row_reg, int'(k_reg));
    assign mac_clear = (state_reg == ST_WR);
    assign mac_acc   = (state_reg == ST_MAC);

    tpu_mac_row u_mac_row (
        .clk    (clk),
        .rst    (rst),
        .clear  (mac_clear),
        .acc_en (mac_acc),
        .a      (a_lane),
        .b_row  (eng_rd_reg),
        .result (mac_result)
    );

    // Sequencer: row loop of RD_A, four MAC steps and a writeback; owns busy/done
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            row_reg   <= '0;
            k_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            a_row_reg <= '0;
        end else begin
            if (bus_wr && fin_hit) begin
                done_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                        row_reg   <= '0;
                        state_reg <= ST_RD_A;
                    end
                end
                ST_RD_A: begin
                    a_row_reg <= eng_rd_reg;
                    k_reg     <= '0;
                    state_reg <= ST_MAC;
                end
                ST_MAC: begin
                    k_reg <= k_reg + 2'd1;
                    if (k_reg == 2'd3) begin
                        state_reg <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (row_reg == 2'd3) begin
                        state_reg <= ST_DONE;
                    end else begin
                        row_reg   <= row_reg + 2'd1;
                        state_reg <= ST_RD_A;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // ---------------- read return path ----------------
    rsel_t rsel_next;
    rsel_t rsel_reg;
    logic  rd_valid_reg;
    logic  stat_reg;

    // Classify the read target at request time
    always_comb begin
        rsel_next = RSEL_ZERO;
        if (buf_hit) begin
            rsel_next = RSEL_BUF;
        end else if (en_hit) begin
            rsel_next = RSEL_ENABLE;
        end else if (fin_hit) begin
            rsel_next = RSEL_FINISH;
        end
    end

    // Two-stage read: capture target/status at the request edge, drive data one edge later
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_reg <= 1'b0;
            rsel_reg     <= RSEL_ZERO;
            stat_reg     <= 1'b0;
            axi_rdata    <= '0;
        end else begin
            rd_valid_reg <= bus_rd;
            rsel_reg     <= bus_rd ? rsel_next : RSEL_ZERO;
            stat_reg     <= (rsel_next == RSEL_ENABLE) ? busy_reg : done_reg;
            if (rd_valid_reg) begin
                case (rsel_reg)
                    RSEL_BUF:    axi_rdata <= bus_rd_reg;
                    RSEL_ENABLE: axi_rdata <= {63'd0, stat_reg};
                    RSEL_FINISH: axi_rdata <= {63'd0, stat_reg};
                    default:     axi_rdata <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tpu.sv
// tb_tpu: directed, table-driven bench for the tpu accelerator.
module tb_tpu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        axi_req = 1'b0;
    logic        axi_we = 1'b0;
    logic [63:0] axi_addr = '0;
    logic [63:0] axi_wdata = '0;
    logic [63:0] axi_rdata;

    always #5 clk = ~clk;

    tpu dut (
        .clk       (clk),
        .rst       (rst),
        .axi_req   (axi_req),
        .axi_we    (axi_we),
        .axi_addr  (axi_addr),
        .axi_wdata (axi_wdata),
        .axi_rdata (axi_rdata)
    );

    localparam logic [63:0] BUF_A    = 64'h4000_0000;
    localparam logic [63:0] A_A      = 64'h4000_0080;
    localparam logic [63:0] B_A      = 64'h4000_0100;
    localparam logic [63:0] ENABLE_A = 64'h4001_7000;
    localparam logic [63:0] FINISH_A = 64'h4001_7008;

    localparam logic [63:0] B0 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] B1 = 64'h0008_0007_0006_0005;
    localparam logic [63:0] B2 = 64'h000C_000B_000A_0009;
    localparam logic [63:0] B3 = 64'h0010_000F_000E_000D;

`ifdef TPU_SATURATE_EN
    localparam logic [63:0] OVF_C0 = 64'hFFFC_8000_7FFF_7FFF;
`else
    localparam logic [63:0] OVF_C0 = 64'hFFFC_7FFA_7FF8_FFFE;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [63:0] data;   // write data, or expected read data
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Write: request held across one rising edge (E0)
    task automatic bus_write(input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        axi_req = 1'b1; axi_we = 1'b1; axi_addr = a; axi_wdata = d;
        @(posedge clk);
        #1;
        axi_req = 1'b0; axi_we = 1'b0;
        $display("WR addr=%h data=%h", a, d);
    endtask

    // Read: request at E0, sample just after E2
    task automatic bus_read(input logic [63:0] a, output logic [63:0] d);
        @(negedge clk);
        axi_req = 1'b1; axi_we = 1'b0; axi_addr = a;
        @(posedge clk);
        #1;
        axi_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        d = axi_rdata;
        $display("RD addr=%h data=%h", a, d);
    endtask

    function automatic void add_wr(input logic [63:0] a, input logic [63:0] d);
        vec_t v;
        v.we = 1'b1; v.addr = a; v.data = d; v.name = "wr";
        vecs.push_back(v);
    endfunction

    function automatic void add_rd(input logic [63:0] a, input logic [63:0] e, input string n);
        vec_t v;
        v.we = 1'b0; v.addr = a; v.data = e; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic run_table();
        logic [63:0] d;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, d);
                check(vecs[i].name, d, vecs[i].data);
            end
        end
        vecs.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        bit          got;

        // Reset state
        rst = 1'b0;
        wait_cycles(3);
        @(negedge clk);
        check("reset_rdata", axi_rdata, 64'd0);
        rst = 1'b1;

        // Status after reset, then load A = identity and B
        add_rd(FINISH_A, 64'd0, "finish_after_reset");
        add_rd(ENABLE_A, 64'd0, "enable_after_reset");
        add_wr(A_A + 64'h00, 64'h0000_0000_0000_0001);
        add_wr(A_A + 64'h08, 64'h0000_0000_0001_0000);
        add_wr(A_A + 64'h10, 64'h0000_0001_0000_0000);
        add_wr(A_A + 64'h18, 64'h0001_0000_0000_0000);
        add_wr(B_A + 64'h00, B0);
        add_wr(B_A + 64'h08, B1);
        add_wr(B_A + 64'h10, B2);
        add_wr(B_A + 64'h18, B3);
        run_table();

        // Identity run: busy during, done by 28 cycles after the enable edge
        bus_write(ENABLE_A, 64'd1);
        wait_cycles(4);
        bus_read(ENABLE_A, d);
        check("busy_running", d, 64'd1);
        bus_read(FINISH_A, d);
        check("done_not_early", d, 64'd0);
        wait_cycles(17);
        bus_read(FINISH_A, d);
        check("done_by_28", d, 64'd1);

        // Results, out-of-map writes, busy cleared
        add_rd(ENABLE_A, 64'd0, "busy_cleared");
        add_rd(BUF_A + 64'h00, B0, "ident_c0");
        add_rd(BUF_A + 64'h08, B1, "ident_c1");
        add_rd(BUF_A + 64'h10, B2, "ident_c2");
        add_rd(BUF_A + 64'h18, B3, "ident_c3");
        add_wr(64'h4000_0800, 64'hDEAD_BEEF_0000_1111);
        add_wr(64'h5000_0000, 64'hCAFE_F00D_2222_3333);
        add_rd(64'h4000_0800, 64'd0, "w100_reads_zero");
        add_rd(64'h5000_0000, 64'd0, "miss_reads_zero");
        add_rd(BUF_A, B0, "word0_unchanged");
        run_table();

        // Second ENABLE while busy must not restart the run
        bus_write(BUF_A, 64'hFFFF_FFFF_FFFF_FFFF);
        bus_write(ENABLE_A, 64'd1);
        wait_cycles(2);
        bus_write(ENABLE_A, 64'd1);
        wait_cycles(24);
        bus_read(FINISH_A, d);
        check("single_run_done_28", d, 64'd1);
        add_rd(BUF_A + 64'h00, B0, "rerun_c0");
        add_rd(BUF_A + 64'h18, B3, "rerun_c3");
        add_wr(FINISH_A, 64'd0);
        add_rd(FINISH_A, 64'd0, "done_cleared");
        run_table();

        // Reset mid-computation aborts with no further buffer writes
        bus_write(BUF_A + 64'h18, 64'h0000_0000_0000_1234);
        bus_read(BUF_A, d);
        check("pre_reset_read", d, B0);
        bus_write(ENABLE_A, 64'd1);
        wait_cycles(8);
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(2);
        @(negedge clk);
        check("midrun_reset_rdata", axi_rdata, 64'd0);
        rst = 1'b1;
        wait_cycles(30);
        add_rd(ENABLE_A, 64'd0, "midrun_reset_busy");
        add_rd(FINISH_A, 64'd0, "midrun_reset_done");
        add_rd(BUF_A + 64'h18, 64'h0000_0000_0000_1234, "aborted_no_write");
        // Overflow operands
        add_wr(A_A + 64'h00, 64'h0000_0000_FFFF_7FFF);
        add_wr(A_A + 64'h08, 64'd0);
        add_wr(A_A + 64'h10, 64'd0);
        add_wr(A_A + 64'h18, 64'd0);
        add_wr(B_A + 64'h00, 64'h0000_FFFF_0003_0002);
        add_wr(B_A + 64'h08, 64'h0004_0007_0005_0000);
        add_wr(B_A + 64'h10, 64'd0);
        add_wr(B_A + 64'h18, 64'd0);
        run_table();

        // Fresh enable after reset, polled every 10 cycles with a bound
        bus_write(ENABLE_A, 64'd1);
        got = 1'b0;
        for (int p = 0; p < 6 && !got; p++) begin
            wait_cycles(10);
            bus_read(FINISH_A, d);
            if (d[0]) got = 1'b1;
        end
        check("fresh_run_done", {63'd0, got}, 64'd1);
        add_rd(BUF_A + 64'h00, OVF_C0, "overflow_c0");
        add_rd(BUF_A + 64'h08, 64'd0, "overflow_c1");
        add_rd(BUF_A + 64'h18, 64'd0, "overflow_c3");
        run_table();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
